// File: rtl/udp_pkg.sv
// Shared state encoding, error codes and the one's-complement fold used by the UDP decoder
// and its checksum accumulator.
package udp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CHECK,
        DROP
    } udp_state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CSUM  = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    localparam logic [7:0] UDP_PROTO     = 8'h11;
    localparam int         UDP_HDR_BYTES = 8;

    // Two folds are always enough: the first leaves at most a 17-bit value.
    function automatic logic [15:0] ones_fold16(input logic [31:0] acc);
        logic [31:0] t;
        t = {16'h0000, acc[31:16]} + {16'h0000, acc[15:0]};
        t = {16'h0000, t[31:16]} + {16'h0000, t[15:0]};
        return t[15:0];
    endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// One's-complement checksum accumulator: seed, add a byte-masked stream word, fold.
// Shared between the UDP decoder and the planned encoder.
module udp_csum_acc
    import udp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                seed_en_i,
    input  logic [31:0]         seed_i,
    input  logic                add_en_i,
    input  logic [DATA_W-1:0]   word_i,
    input  logic [DATA_W/8-1:0] keep_i,
    output logic [DATA_W-1:0]   masked_o,
    output logic [15:0]         fold_o
);

    logic [31:0] acc_q, acc_d;
    logic [31:0] word_sum;

    // keep bit b guards byte b, so the MSB of keep lines up with the first byte on the wire
    always_comb begin
        masked_o = '0;
        for (int b = 0; b < DATA_W/8; b++) begin
            masked_o[8*b +: 8] = keep_i[b] ? word_i[8*b +: 8] : 8'h00;
        end
    end

    always_comb begin
        word_sum = '0;
        for (int h = 0; h < DATA_W/16; h++) begin
            word_sum = word_sum + {16'h0000, masked_o[16*h +: 16]};
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (seed_en_i) begin
            acc_d = seed_i;
        end
        if (add_en_i) begin
            acc_d = (seed_en_i ? seed_i : acc_q) + word_sum;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign fold_o = ones_fold16(acc_q);

endmodule

// File: rtl/udp_decoder_param.sv
// Parameterised UDP receive decoder (DATA_W 32 or 64): header capture, payload forwarding
// with keep flags, checksum verification. Optional UDP_PORT_FILTER_EN drops foreign ports.
module udp_decoder_param
    import udp_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          MAX_LEN    = 1500,
    parameter logic [15:0] LOCAL_PORT = 16'h2694
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                data_valid,
    input  logic [DATA_W-1:0]   data,
    input  logic [31:0]         src_ip,
    input  logic [31:0]         dest_ip,
    input  logic [15:0]         len_udp,
    output logic [15:0]         src_port,
    output logic [15:0]         dest_port,
    output logic [15:0]         len_data,
    output logic [DATA_W-1:0]   data_udp,
    output logic [DATA_W/8-1:0] data_keep,
    output logic                wr_en,
    output logic                fin,
    output logic                ok,
    output logic [1:0]          err_code
);

    localparam int BYTES     = DATA_W / 8;
    localparam int HDR_WORDS = UDP_HDR_BYTES / BYTES;

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("udp_decoder_param: DATA_W must be 32 or 64");
    end

    udp_state_e        state_q, state_d;
    logic              hdr_cnt_q, hdr_cnt_d;
    logic [15:0]       bytes_left_q, bytes_left_d;
    logic [15:0]       csum_rx_q, csum_rx_d;
    logic [15:0]       src_port_q, src_port_d;
    logic [15:0]       dest_port_q, dest_port_d;
    logic [15:0]       len_data_q, len_data_d;
    logic [1:0]        drop_err_q, drop_err_d;
    logic [DATA_W-1:0] data_udp_q, data_udp_d;
    logic [BYTES-1:0]  data_keep_q, data_keep_d;
    logic              wr_en_q, wr_en_d, fin_q, fin_d, ok_q, ok_d;
    logic [1:0]        err_q, err_d;

    logic              seed_en, add_en, port_bad, len_bad, hdr_last, is_last_pay, csum_good;
    logic [47:0]       hdr_view;
    logic [15:0]       hdr_len, csum_fold;
    logic [1:0]        hdr_err;
    logic [31:0]       seed;
    logic [BYTES-1:0]  keep_last, add_keep;
    logic [DATA_W-1:0] masked;

    // hdr_view is {dest port, length, checksum} as seen on the final header word
    if (DATA_W == 64) begin : g_hdr64
        assign hdr_view = data[47:0];
    end else begin : g_hdr32
        assign hdr_view = {dest_port_q, data};
    end

`ifdef UDP_PORT_FILTER_EN
    assign port_bad = (hdr_view[47:32] != LOCAL_PORT);
`else
    logic unused_local_port;
    assign port_bad          = 1'b0;
    assign unused_local_port = ^LOCAL_PORT;
`endif

    assign hdr_len     = hdr_view[31:16];
    assign len_bad     = (hdr_len != len_udp) || (hdr_len < 16'(UDP_HDR_BYTES))
                         || (32'(hdr_len) > 32'(MAX_LEN));
    assign hdr_err     = len_bad ? ERR_LEN : ERR_ABORT;
    assign hdr_last    = (HDR_WORDS == 1) || (!start && hdr_cnt_q);
    assign is_last_pay = (bytes_left_q <= 16'(BYTES));
    assign csum_good   = (csum_fold == 16'hFFFF) || (csum_rx_q == 16'h0000);
    assign seed        = 32'(src_ip[31:16]) + 32'(src_ip[15:0]) + 32'(dest_ip[31:16])
                         + 32'(dest_ip[15:0]) + 32'(UDP_PROTO) + 32'(len_udp);

    always_comb begin
        keep_last = '0;
        for (int b = 0; b < BYTES; b++) begin
            keep_last[b] = (16'(BYTES - 1 - b) < bytes_left_q);
        end
    end

    assign seed_en  = data_valid && start;
    assign add_en   = data_valid && (start || state_q == HDR || state_q == PAYLOAD);
    assign add_keep = (state_q == PAYLOAD && !start && is_last_pay) ? keep_last : '1;

    udp_csum_acc #(.DATA_W(DATA_W)) u_csum (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed_en_i (seed_en),
        .seed_i    (seed),
        .add_en_i  (add_en),
        .word_i    (data),
        .keep_i    (add_keep),
        .masked_o  (masked),
        .fold_o    (csum_fold)
    );

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        bytes_left_d = bytes_left_q;
        csum_rx_d    = csum_rx_q;
        src_port_d   = src_port_q;
        dest_port_d  = dest_port_q;
        len_data_d   = len_data_q;
        drop_err_d   = drop_err_q;
        data_udp_d   = data_udp_q;
        data_keep_d  = data_keep_q;
        wr_en_d      = 1'b0;
        fin_d        = 1'b0;
        ok_d         = 1'b0;
        err_d        = ERR_NONE;

        // CHECK always closes its datagram, even when a new start shares the cycle
        if (state_q == CHECK) begin
            fin_d   = 1'b1;
            ok_d    = csum_good;
            err_d   = csum_good ? ERR_NONE : ERR_CSUM;
            state_d = IDLE;
        end else if (data_valid && start && state_q != IDLE) begin
            fin_d = 1'b1;
            err_d = ERR_ABORT;
        end

        if (data_valid && (start || state_q == HDR)) begin
            if (start) begin
                src_port_d  = data[DATA_W-1 -: 16];
                dest_port_d = data[DATA_W-17 -: 16];
            end
            if (hdr_last) begin
                hdr_cnt_d  = 1'b0;
                csum_rx_d  = hdr_view[15:0];
                len_data_d = (hdr_len < 16'(UDP_HDR_BYTES)) ? 16'h0000
                             : hdr_len - 16'(UDP_HDR_BYTES);
                if (len_bad || port_bad) begin
                    drop_err_d = hdr_err;
                    if (len_udp > 16'(UDP_HDR_BYTES)) begin
                        state_d      = DROP;
                        bytes_left_d = len_udp - 16'(UDP_HDR_BYTES);
                    end else begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                        ok_d    = 1'b0;
                        err_d   = hdr_err;
                    end
                end else if (hdr_len == 16'(UDP_HDR_BYTES)) begin
                    state_d = CHECK;
                end else begin
                    state_d      = PAYLOAD;
                    bytes_left_d = hdr_len - 16'(UDP_HDR_BYTES);
                end
            end else begin
                state_d   = HDR;
                hdr_cnt_d = 1'b1;
            end
        end else if (data_valid && state_q == PAYLOAD) begin
            wr_en_d     = 1'b1;
            data_udp_d  = masked;
            data_keep_d = add_keep;
            if (is_last_pay) begin
                state_d = CHECK;
            end else begin
                bytes_left_d = bytes_left_q - 16'(BYTES);
            end
        end else if (data_valid && state_q == DROP) begin
            if (is_last_pay) begin
                state_d = IDLE;
                fin_d   = 1'b1;
                err_d   = drop_err_q;
            end else begin
                bytes_left_d = bytes_left_q - 16'(BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hdr_cnt_q    <= 1'b0;
            bytes_left_q <= '0;
            csum_rx_q    <= '0;
            src_port_q   <= '0;
            dest_port_q  <= '0;
            len_data_q   <= '0;
            drop_err_q   <= ERR_NONE;
            data_udp_q   <= '0;
            data_keep_q  <= '0;
            wr_en_q      <= 1'b0;
            fin_q        <= 1'b0;
            ok_q         <= 1'b0;
            err_q        <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            bytes_left_q <= bytes_left_d;
            csum_rx_q    <= csum_rx_d;
            src_port_q   <= src_port_d;
            dest_port_q  <= dest_port_d;
            len_data_q   <= len_data_d;
            drop_err_q   <= drop_err_d;
            data_udp_q   <= data_udp_d;
            data_keep_q  <= data_keep_d;
            wr_en_q      <= wr_en_d;
            fin_q        <= fin_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
        end
    end

    assign src_port  = src_port_q;
    assign dest_port = dest_port_q;
    assign len_data  = len_data_q;
    assign data_udp  = data_udp_q;
    assign data_keep = data_keep_q;
    assign wr_en     = wr_en_q;
    assign fin       = fin_q;
    assign ok        = ok_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_udp_decoder_param.sv
// Directed bench for udp_decoder_param: a 32-bit and a 64-bit instance share clock and reset;
// a negedge monitor logs written payload words and fin events for the test tasks to check.
module tb_udp_decoder_param;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] srcIp = 32'h9801331b;
    logic [31:0] destIp = 32'h980e5e4b;
    logic [15:0] lenUdp = 16'd19;

    logic        start32 = 1'b0, valid32 = 1'b0;
    logic [31:0] data32 = '0;
    logic [15:0] srcPort32, destPort32, lenData32;
    logic [31:0] dataUdp32;
    logic [3:0]  keep32;
    logic        wrEn32, fin32, ok32;
    logic [1:0]  err32;

    logic        start64 = 1'b0, valid64 = 1'b0;
    logic [63:0] data64 = '0;
    logic [15:0] srcPort64, destPort64, lenData64;
    logic [63:0] dataUdp64;
    logic [7:0]  keep64;
    logic        wrEn64, fin64, ok64;
    logic [1:0]  err64;

    udp_decoder_param #(.DATA_W(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .data_valid(valid32), .data(data32),
        .src_ip(srcIp), .dest_ip(destIp), .len_udp(lenUdp),
        .src_port(srcPort32), .dest_port(destPort32), .len_data(lenData32),
        .data_udp(dataUdp32), .data_keep(keep32), .wr_en(wrEn32), .fin(fin32),
        .ok(ok32), .err_code(err32)
    );

    udp_decoder_param #(.DATA_W(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start64), .data_valid(valid64), .data(data64),
        .src_ip(srcIp), .dest_ip(destIp), .len_udp(lenUdp),
        .src_port(srcPort64), .dest_port(destPort64), .len_data(lenData64),
        .data_udp(dataUdp64), .data_keep(keep64), .wr_en(wrEn64), .fin(fin64),
        .ok(ok64), .err_code(err64)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;

    logic [31:0] wData32[$];
    logic [3:0]  wKeep32[$];
    int          finCount32, finCyc32, lastWrCyc32;
    logic        finOk32;
    logic [1:0]  finErr32;
    logic [63:0] wData64[$];
    logic [7:0]  wKeep64[$];
    int          finCount64, finCyc64, lastWrCyc64;
    logic        finOk64;
    logic [1:0]  finErr64;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wrEn32) begin wData32.push_back(dataUdp32); wKeep32.push_back(keep32); lastWrCyc32 = cyc; end
        if (fin32) begin finCount32++; finOk32 = ok32; finErr32 = err32; finCyc32 = cyc; end
        if (wrEn64) begin wData64.push_back(dataUdp64); wKeep64.push_back(keep64); lastWrCyc64 = cyc; end
        if (fin64) begin finCount64++; finOk64 = ok64; finErr64 = err64; finCyc64 = cyc; end
    end

    task automatic clear_sb();
        wData32.delete(); wKeep32.delete(); wData64.delete(); wKeep64.delete();
        finCount32 = 0; finCyc32 = -1; lastWrCyc32 = -1; finOk32 = 1'b0; finErr32 = 2'd0;
        finCount64 = 0; finCyc64 = -1; lastWrCyc64 = -1; finOk64 = 1'b0; finErr64 = 2'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start32 = 1'b0; valid32 = 1'b0; start64 = 1'b0; valid64 = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_sb();
    endtask

    task automatic word32(input logic s, input logic [31:0] d);
        @(negedge clk);
        start32 = s; valid32 = 1'b1; data32 = d;
    endtask

    task automatic idle32(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start32 = 1'b0; valid32 = 1'b0;
        end
    endtask

    task automatic word64(input logic s, input logic [63:0] d);
        @(negedge clk);
        start64 = s; valid64 = 1'b1; data64 = d;
    endtask

    task automatic idle64(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start64 = 1'b0; valid64 = 1'b0;
        end
    endtask

    // "Hello World" datagram, 11 payload bytes over three 32-bit words
    task automatic send_hello32(input logic [15:0] dport, input logic [15:0] csum, input logic [31:0] p1);
        srcIp = 32'h9801331b; destIp = 32'h980e5e4b; lenUdp = 16'd19;
        word32(1'b1, {16'ha08f, dport});
        word32(1'b0, {16'h0013, csum});
        word32(1'b0, 32'h48656c6c);
        word32(1'b0, p1);
        word32(1'b0, 32'h726c6400);
        idle32(4);
    endtask

    task automatic test_reset();
        do_reset();
        testsRun++;
        if ({srcPort32, destPort32, lenData32} !== 48'h0) begin
            testsFailed++; $display("[TB] FAIL reset_fields32: got %h expected 0", {srcPort32, destPort32, lenData32});
        end
        testsRun++;
        if ({wrEn32, fin32, ok32, err32, keep32, dataUdp32} !== '0) begin
            testsFailed++; $display("[TB] FAIL reset_outputs32: got %b/%b/%b/%h expected all 0", wrEn32, fin32, ok32, err32);
        end
        testsRun++;
        if ({srcPort64, destPort64, lenData64, wrEn64, fin64, ok64, err64, keep64, dataUdp64} !== '0) begin
            testsFailed++; $display("[TB] FAIL reset_outputs64: got ports %h/%h data %h expected all 0", srcPort64, destPort64, dataUdp64);
        end
    endtask

    task automatic test_good_datagram();
        logic [31:0] expD [3];
        logic [3:0]  expK [3];
        expD = '{32'h48656c6c, 32'h6f20576f, 32'h726c6400};
        expK = '{4'b1111, 4'b1111, 4'b1110};
        do_reset();
        send_hello32(16'h2694, 16'h2560, 32'h6f20576f);
        testsRun++;
        if (wData32.size() != 3) begin
            testsFailed++; $display("[TB] FAIL good_wr_count: got %0d expected 3", wData32.size());
        end
        for (int i = 0; i < 3 && i < wData32.size(); i++) begin
            testsRun++;
            if (wData32[i] !== expD[i] || wKeep32[i] !== expK[i]) begin
                testsFailed++; $display("[TB] FAIL good_payload[%0d]: got %h/%b expected %h/%b", i, wData32[i], wKeep32[i], expD[i], expK[i]);
            end
        end
        testsRun++;
        if (finCount32 != 1 || finOk32 !== 1'b1 || finErr32 !== 2'd0) begin
            testsFailed++; $display("[TB] FAIL good_fin: got count %0d ok %b err %0d expected 1/1/0", finCount32, finOk32, finErr32);
        end
        testsRun++;
        if (finCyc32 != lastWrCyc32 + 1) begin
            testsFailed++; $display("[TB] FAIL good_fin_timing: got fin at %0d expected %0d", finCyc32, lastWrCyc32 + 1);
        end
        testsRun++;
        if (srcPort32 !== 16'ha08f || destPort32 !== 16'h2694 || lenData32 !== 16'd11) begin
            testsFailed++; $display("[TB] FAIL good_header: got %h %h %0d expected a08f 2694 11", srcPort32, destPort32, lenData32);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        send_hello32(16'h2694, 16'h2561, 32'h6f20576f);
        testsRun++;
        if (wData32.size() != 3) begin
            testsFailed++; $display("[TB] FAIL badcsum_wr_count: got %0d expected 3", wData32.size());
        end
        testsRun++;
        if (finCount32 != 1 || finOk32 !== 1'b0 || finErr32 !== 2'd1) begin
            testsFailed++; $display("[TB] FAIL badcsum_fin: got count %0d ok %b err %0d expected 1/0/1", finCount32, finOk32, finErr32);
        end
    endtask

    task automatic test_gaps64();
        do_reset();
        srcIp = 32'h9801331b; destIp = 32'h980e5e4b; lenUdp = 16'd19;
        word64(1'b1, 64'ha08f2694_00132560);
        idle64(2);
        word64(1'b0, 64'h48656c6c_6f20576f);
        idle64(3);
        testsRun++;
        if (wData64.size() != 1 || finCount64 != 0) begin
            testsFailed++; $display("[TB] FAIL gap_hold: got %0d writes %0d fins expected 1/0", wData64.size(), finCount64);
        end
        word64(1'b0, 64'h726c6400_00000000);
        idle64(4);
        testsRun++;
        if (wData64.size() != 2) begin
            testsFailed++; $display("[TB] FAIL gap_wr_count: got %0d expected 2", wData64.size());
        end else begin
            testsRun++;
            if (wData64[0] !== 64'h48656c6c6f20576f || wKeep64[0] !== 8'hFF) begin
                testsFailed++; $display("[TB] FAIL gap_word0: got %h/%h expected 48656c6c6f20576f/ff", wData64[0], wKeep64[0]);
            end
            testsRun++;
            if (wData64[1] !== 64'h726c640000000000 || wKeep64[1] !== 8'hE0) begin
                testsFailed++; $display("[TB] FAIL gap_word1: got %h/%h expected 726c640000000000/e0", wData64[1], wKeep64[1]);
            end
        end
        testsRun++;
        if (finCount64 != 1 || finOk64 !== 1'b1 || finErr64 !== 2'd0 || finCyc64 != lastWrCyc64 + 1) begin
            testsFailed++; $display("[TB] FAIL gap_fin: got count %0d ok %b err %0d expected 1/1/0 one cycle after last write", finCount64, finOk64, finErr64);
        end
        testsRun++;
        if (lenData64 !== 16'd11 || destPort64 !== 16'h2694) begin
            testsFailed++; $display("[TB] FAIL gap_header: got len %0d port %h expected 11 2694", lenData64, destPort64);
        end
    endtask

    task automatic test_length_mismatch();
        do_reset();
        srcIp = 32'h9801331b; destIp = 32'h980e5e4b; lenUdp = 16'd20;
        word32(1'b1, 32'ha08f2694);
        word32(1'b0, 32'h00132560);
        word32(1'b0, 32'h48656c6c);
        word32(1'b0, 32'h6f20576f);
        idle32(2);
        testsRun++;
        if (finCount32 != 0) begin
            testsFailed++; $display("[TB] FAIL len_early_fin: got %0d expected 0 before 20 bytes", finCount32);
        end
        word32(1'b0, 32'h726c6400);
        idle32(3);
        testsRun++;
        if (finCount32 != 1 || finOk32 !== 1'b0 || finErr32 !== 2'd2) begin
            testsFailed++; $display("[TB] FAIL len_fin: got count %0d ok %b err %0d expected 1/0/2", finCount32, finOk32, finErr32);
        end
        testsRun++;
        if (wData32.size() != 0) begin
            testsFailed++; $display("[TB] FAIL len_no_write: got %0d writes expected 0", wData32.size());
        end
    endtask

    task automatic test_zero_checksum();
        do_reset();
        send_hello32(16'h2694, 16'h0000, 32'h6f20576e);
        testsRun++;
        if (finCount32 != 1 || finOk32 !== 1'b1 || finErr32 !== 2'd0) begin
            testsFailed++; $display("[TB] FAIL zerocsum_fin: got count %0d ok %b err %0d expected 1/1/0", finCount32, finOk32, finErr32);
        end
        testsRun++;
        if (wData32.size() != 3 || wData32[1] !== 32'h6f20576e) begin
            testsFailed++; $display("[TB] FAIL zerocsum_payload: got %0d writes expected 3 with word1 6f20576e", wData32.size());
        end
    endtask

    task automatic test_abort();
        do_reset();
        srcIp = 32'h9801331b; destIp = 32'h980e5e4b; lenUdp = 16'd19;
        word32(1'b1, 32'ha08f2694);
        word32(1'b0, 32'h00132560);
        word32(1'b0, 32'h48656c6c);
        word32(1'b1, 32'h11112222);
        idle32(3);
        testsRun++;
        if (finCount32 != 1 || finOk32 !== 1'b0 || finErr32 !== 2'd3) begin
            testsFailed++; $display("[TB] FAIL abort_fin: got count %0d ok %b err %0d expected 1/0/3", finCount32, finOk32, finErr32);
        end
        testsRun++;
        if (wData32.size() != 1) begin
            testsFailed++; $display("[TB] FAIL abort_writes: got %0d expected 1", wData32.size());
        end
        testsRun++;
        if (srcPort32 !== 16'h1111 || destPort32 !== 16'h2222) begin
            testsFailed++; $display("[TB] FAIL abort_new_header: got %h %h expected 1111 2222", srcPort32, destPort32);
        end
    endtask

    task automatic test_port_filter();
        int   expWr;
        logic expOk;
        logic [1:0] expErr;
`ifdef UDP_PORT_FILTER_EN
        expWr = 0; expOk = 1'b0; expErr = 2'd3;
`else
        expWr = 3; expOk = 1'b1; expErr = 2'd0;
`endif
        do_reset();
        send_hello32(16'h1234, 16'h39c0, 32'h6f20576f);
        testsRun++;
        if (wData32.size() != expWr) begin
            testsFailed++; $display("[TB] FAIL filter_writes: got %0d expected %0d", wData32.size(), expWr);
        end
        testsRun++;
        if (finCount32 != 1 || finOk32 !== expOk || finErr32 !== expErr) begin
            testsFailed++; $display("[TB] FAIL filter_fin: got count %0d ok %b err %0d expected 1/%b/%0d", finCount32, finOk32, finErr32, expOk, expErr);
        end
        testsRun++;
        if (destPort32 !== 16'h1234) begin
            testsFailed++; $display("[TB] FAIL filter_port: got %h expected 1234", destPort32);
        end
    endtask

    task automatic test_reset_mid_payload();
        do_reset();
        srcIp = 32'h9801331b; destIp = 32'h980e5e4b; lenUdp = 16'd19;
        word32(1'b1, 32'ha08f2694);
        word32(1'b0, 32'h00132560);
        word32(1'b0, 32'h48656c6c);
        @(negedge clk);
        start32 = 1'b0; valid32 = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        testsRun++;
        if ({srcPort32, destPort32, lenData32, dataUdp32, keep32, wrEn32, fin32, ok32, err32} !== '0) begin
            testsFailed++; $display("[TB] FAIL midreset_outputs: got ports %h/%h len %0d wr %b data %h expected all 0", srcPort32, destPort32, lenData32, wrEn32, dataUdp32);
        end
        clear_sb();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle32(5);
        testsRun++;
        if (finCount32 != 0 || wData32.size() != 0) begin
            testsFailed++; $display("[TB] FAIL midreset_no_fin: got %0d fins %0d writes expected 0/0", finCount32, wData32.size());
        end
    endtask

    initial begin
        clear_sb();
        test_reset();
        test_good_datagram();
        test_bad_checksum();
        test_gaps64();
        test_length_mismatch();
        test_zero_checksum();
        test_abort();
        test_port_filter();
        test_reset_mid_payload();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
